// File: rtl/npu_quant_pkg.sv
`default_nettype none
// ============================================================================
// Module   : npu_quant_pkg
// Purpose  : Shared quantization types, widths and helpers for the NPU
//            post-processing engines (requant, gelu, softmax, layernorm).
// Contents : requant_cfg_t, requant_state_t, sat_result_t, sat_to_int8()
// Revision : 1.0 - initial release
// ============================================================================
package npu_quant_pkg;

  localparam int REQ_ACC_WIDTH    = 32;
  localparam int REQ_DATA_WIDTH   = 8;
  localparam int REQ_SCALE_WIDTH  = 16;
  localparam int REQ_SHIFT_WIDTH  = 6;
  localparam int REQ_MAX_ELEMENTS = 4096;
  localparam int REQ_LATENCY      = 3;

  // signed(acc) * unsigned(scale) needs one extra bit for the scale's sign.
  localparam int REQ_PROD_WIDTH = REQ_ACC_WIDTH + REQ_SCALE_WIDTH + 1;
  // One more bit of headroom for the rounding bias and zero-point add.
  localparam int REQ_SUM_WIDTH  = REQ_PROD_WIDTH + 1;

  localparam logic signed [REQ_DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(REQ_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [REQ_DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(REQ_DATA_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [REQ_SCALE_WIDTH-1:0]        scale;
    logic [REQ_SHIFT_WIDTH-1:0]        shift;
    logic signed [REQ_DATA_WIDTH-1:0]  zero_point;
  } requant_cfg_t;

  typedef struct packed {
    logic signed [REQ_DATA_WIDTH-1:0]  value;
    logic                              saturated;
  } sat_result_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } requant_state_t;

  // Clamp a wide signed value into the INT8 range and flag any clipping.
  function automatic sat_result_t sat_to_int8(input logic signed [REQ_SUM_WIDTH-1:0] v);
    sat_result_t res;
    if (v > REQ_SUM_WIDTH'(OUT_MAX)) begin
      res.value     = OUT_MAX;
      res.saturated = 1'b1;
    end else if (v < REQ_SUM_WIDTH'(OUT_MIN)) begin
      res.value     = OUT_MIN;
      res.saturated = 1'b1;
    end else begin
      res.value     = v[REQ_DATA_WIDTH-1:0];
      res.saturated = 1'b0;
    end
    return res;
  endfunction

endpackage : npu_quant_pkg
`default_nettype wire

// File: rtl/requant_pipe.sv
`default_nettype none
// ============================================================================
// Module   : requant_pipe
// Purpose  : 3-stage requantization datapath with a valid shift chain.
//            S1 product, S2 round/shift/zero-point, S3 saturate/output.
// Ports    : clk, rst_n        clock / synchronous active-low reset
//            cfg               scale, shift (pre-clamped), zero_point
//            acc, in_valid     accumulator sample and its qualifier
//            data, valid       INT8 result, valid for one cycle
//            sat_flag          result was clipped (qualified by valid)
// Revision : 1.0 - initial release
// ============================================================================
module requant_pipe
  import npu_quant_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  requant_cfg_t                      cfg,
  input  logic signed [REQ_ACC_WIDTH-1:0]   acc,
  input  logic                              in_valid,
  output logic signed [REQ_DATA_WIDTH-1:0]  data,
  output logic                              valid,
  output logic                              sat_flag
);

  logic signed [REQ_PROD_WIDTH-1:0] r_prod;
  logic signed [REQ_SUM_WIDTH-1:0]  r_sum;
  logic                             r_v1;
  logic                             r_v2;

  logic signed [REQ_SUM_WIDTH-1:0]  w_bias;
  logic signed [REQ_SUM_WIDTH-1:0]  w_rounded;
  logic signed [REQ_SUM_WIDTH-1:0]  w_shifted;
  logic signed [REQ_SUM_WIDTH-1:0]  w_sum;
  sat_result_t                      w_sat;

  // Half-LSB bias before the arithmetic shift gives round-half-toward-+inf
  // for both signs; no bias when the shift is zero.
  always_comb begin
    w_bias    = '0;
    if (cfg.shift != '0) begin
      w_bias = REQ_SUM_WIDTH'(1) << (cfg.shift - 1'b1);
    end
    w_rounded = REQ_SUM_WIDTH'(r_prod) + w_bias;
    w_shifted = w_rounded >>> cfg.shift;
    w_sum     = w_shifted + REQ_SUM_WIDTH'($signed(cfg.zero_point));
    w_sat     = sat_to_int8(r_sum);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prod   <= '0;
      r_sum    <= '0;
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      valid    <= 1'b0;
      data     <= '0;
      sat_flag <= 1'b0;
    end else begin
      r_v1  <= in_valid;
      r_v2  <= r_v1;
      valid <= r_v2;
      // Zero-extend scale so the product treats it as unsigned.
      r_prod <= REQ_PROD_WIDTH'(acc) * REQ_PROD_WIDTH'($signed({1'b0, cfg.scale}));
      r_sum  <= w_sum;
      // Output register only updates on a valid result so data holds otherwise.
      if (r_v2) begin
        data     <= w_sat.value;
        sat_flag <= w_sat.saturated;
      end
    end
  end

endmodule : requant_pipe
`default_nettype wire

// File: rtl/requant_engine.sv
`default_nettype none
// ============================================================================
// Module   : requant_engine
// Purpose  : Streaming requantizer, signed accumulators -> signed INT8.
//            Job control (start/busy/done), element counting, config latch
//            and saturation counting around the requant_pipe datapath.
// Ports    : clk, rst_n                  clock / synchronous active-low reset
//            start, busy, done           job handshake
//            num_elements                job length, latched at start
//            scale, shift, zero_point    requant config, latched at start
//            acc_in, acc_valid           input stream (no backpressure)
//            data_out, out_valid         INT8 output stream
//            sat_count                   clipped results in current/last job
// Revision : 1.0 - initial release
// ============================================================================
module requant_engine
  import npu_quant_pkg::*;
#(
  parameter int ACC_WIDTH    = REQ_ACC_WIDTH,
  parameter int DATA_WIDTH   = REQ_DATA_WIDTH,
  parameter int SCALE_WIDTH  = REQ_SCALE_WIDTH,
  parameter int SHIFT_WIDTH  = REQ_SHIFT_WIDTH,
  parameter int MAX_ELEMENTS = REQ_MAX_ELEMENTS
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  input  logic [$clog2(MAX_ELEMENTS)-1:0]  num_elements,
  input  logic [SCALE_WIDTH-1:0]           scale,
  input  logic [SHIFT_WIDTH-1:0]           shift,
  input  logic signed [DATA_WIDTH-1:0]     zero_point,
  input  logic signed [ACC_WIDTH-1:0]      acc_in,
  input  logic                             acc_valid,
  output logic signed [DATA_WIDTH-1:0]     data_out,
  output logic                             out_valid,
  output logic [$clog2(MAX_ELEMENTS)-1:0]  sat_count
);

  localparam int CNT_WIDTH = $clog2(MAX_ELEMENTS);
  localparam logic [SHIFT_WIDTH-1:0] MAX_SHIFT = SHIFT_WIDTH'(ACC_WIDTH + SCALE_WIDTH - 1);

  requant_state_t          state_q;
  requant_state_t          state_d;
  requant_cfg_t            r_cfg;
  logic [CNT_WIDTH-1:0]    r_num;
  logic [CNT_WIDTH-1:0]    r_in_count;
  logic [CNT_WIDTH-1:0]    r_out_count;
  logic [CNT_WIDTH-1:0]    r_sat_count;

  logic                    w_accept;
  logic [SHIFT_WIDTH-1:0]  w_shift_clamped;
  logic                    w_pipe_valid;
  logic                    w_pipe_sat;

  assign w_accept        = (state_q == ST_RUN) && acc_valid && (r_in_count < r_num);
  assign w_shift_clamped = (shift > MAX_SHIFT) ? MAX_SHIFT : shift;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (num_elements == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_in_count == r_num) begin
          state_d = ST_DRAIN;
        end
      end
      // Leave as the final result emerges so done lands one cycle after it.
      ST_DRAIN: begin
        if (w_pipe_valid && (r_out_count == r_num - CNT_WIDTH'(1))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      r_cfg       <= '0;
      r_num       <= '0;
      r_in_count  <= '0;
      r_out_count <= '0;
      r_sat_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        r_num            <= num_elements;
        r_cfg.scale      <= scale;
        r_cfg.shift      <= w_shift_clamped;
        r_cfg.zero_point <= zero_point;
        r_in_count       <= '0;
        r_out_count      <= '0;
        r_sat_count      <= '0;
      end else begin
        if (w_accept) begin
          r_in_count <= r_in_count + CNT_WIDTH'(1);
        end
        if (w_pipe_valid) begin
          r_out_count <= r_out_count + CNT_WIDTH'(1);
          if (w_pipe_sat) begin
            r_sat_count <= r_sat_count + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  requant_pipe u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg      (r_cfg),
    .acc      (acc_in),
    .in_valid (w_accept),
    .data     (data_out),
    .valid    (w_pipe_valid),
    .sat_flag (w_pipe_sat)
  );

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign out_valid = w_pipe_valid;
  assign sat_count = r_sat_count;

endmodule : requant_engine
`default_nettype wire
